// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and helpers for the UART receive path
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - line synchroniser, falling-edge detect and 3-sample majority vote
module uart_rx_sampler (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic uart_rx,
    input  logic sample_a,
    input  logic sample_b,
    output logic fall,
    output logic bit_val
);

    logic [1:0] sync;
    logic       prev;
    logic       s_a;
    logic       s_b;
    logic       line;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sync <= 2'b11;
            prev <= 1'b1;
            s_a  <= 1'b1;
            s_b  <= 1'b1;
        end else begin
            sync <= {sync[0], uart_rx};
            prev <= sync[1];
            if (sample_a) s_a <= sync[1];
            if (sample_b) s_b <= sync[1];
        end
    end

    assign line = sync[1];
    assign fall = prev & ~line;
    // Third vote is the live line, so the bit resolves on the cycle of the last sample.
    assign bit_val = (s_a & s_b) | (s_a & line) | (s_b & line);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - parametrised UART receiver with error flags and one-entry holding register
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 43,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       break_det,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int            CW        = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SMP_A     = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] SMP_B     = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] SMP_C     = CW'(CLK_DIV / 2 + 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    logic [2:0]           state;
    logic [CW-1:0]        clk_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 stop_bad;
    logic                 fall;
    logic                 bit_val;
    logic                 in_frame;
    logic                 wrap;
    logic                 at_sample;
    logic                 done;
    logic                 perr_now;
    logic                 ferr_now;
    logic                 brk_now;

    assign in_frame  = (state != ST_IDLE);
    assign wrap      = (clk_cnt == CNT_LAST);
    assign at_sample = in_frame && (clk_cnt == SMP_C);
    assign done      = (state == ST_STOP) && at_sample && (bit_cnt == STOP_LAST);

    uart_rx_sampler u_sampler (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .sample_a (in_frame && (clk_cnt == SMP_A)),
        .sample_b (in_frame && (clk_cnt == SMP_B)),
        .fall     (fall),
        .bit_val  (bit_val)
    );

    always_comb begin
        perr_now = 1'b0;
        if (PARITY == PAR_EVEN) perr_now = (^shreg) ^ par_bit;
        else if (PARITY == PAR_ODD) perr_now = ~((^shreg) ^ par_bit);
    end

    // Final stop bit is judged from the live vote since it is never registered.
    assign ferr_now = stop_bad | ~bit_val;
    assign brk_now  = ferr_now && (shreg == '0) && !par_bit;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_bad <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (fall) begin
                state    <= ST_START;
                clk_cnt  <= '0;
                bit_cnt  <= '0;
                par_bit  <= 1'b0;
                stop_bad <= 1'b0;
            end
        end else begin
            clk_cnt <= wrap ? '0 : clk_cnt + 1'b1;
            case (state)
                ST_START: begin
                    if (at_sample && bit_val) state <= ST_IDLE;
                    else if (wrap) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (at_sample) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                    if (wrap) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    if (at_sample) par_bit <= bit_val;
                    if (wrap) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (done) begin
                        state <= ST_IDLE;
                    end else begin
                        if (at_sample) stop_bad <= stop_bad | ~bit_val;
                        if (wrap) bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= 8'(shreg);
                    parity_err <= perr_now;
                    frame_err  <= ferr_now;
                    break_det  <= brk_now;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = in_frame;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core against a frame-level reference model
module tb_uart_rx_core;

    localparam int CD [3] = '{43, 43, 16};
    localparam int DB [3] = '{8, 8, 7};
    localparam int PM [3] = '{1, 2, 0};
    localparam int SB [3] = '{1, 1, 2};

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       line [3];
    logic       rdy  [3];
    logic [7:0] dat  [3];
    logic       vld  [3];
    logic       pe   [3];
    logic       fe   [3];
    logic       bk   [3];
    logic       ov   [3];
    logic       bsy  [3];

    int         checks = 0;
    int         failures = 0;
    int         cyc, ovr_cnt, rise_cnt, rise_cyc, busy_rise, busy_fall, rdy_pulse_at;
    logic       rdy_level, vld_prev, busy_prev;
    logic [7:0] cap_data;
    logic       cap_pe, cap_fe, cap_bk;

    always #5 sys_clk = ~sys_clk;

    uart_rx_core u_dut_even (
        .sys_clk(sys_clk), .rst_n(rst_n), .uart_rx(line[0]), .rx_data(dat[0]), .rx_valid(vld[0]),
        .rx_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bk[0]),
        .overrun(ov[0]), .rx_busy(bsy[0])
    );

    uart_rx_core #(.CLK_DIV(43), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_odd (
        .sys_clk(sys_clk), .rst_n(rst_n), .uart_rx(line[1]), .rx_data(dat[1]), .rx_valid(vld[1]),
        .rx_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bk[1]),
        .overrun(ov[1]), .rx_busy(bsy[1])
    );

    uart_rx_core #(.CLK_DIV(16), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_dut_7n2 (
        .sys_clk(sys_clk), .rst_n(rst_n), .uart_rx(line[2]), .rx_data(dat[2]), .rx_valid(vld[2]),
        .rx_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bk[2]),
        .overrun(ov[2]), .rx_busy(bsy[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int s);
        @(posedge sys_clk);
        #1;
        cyc++;
        if (ov[s]) ovr_cnt++;
        if (vld[s] && !vld_prev) begin
            rise_cnt++;
            rise_cyc = cyc;
            cap_data = dat[s];
            cap_pe   = pe[s];
            cap_fe   = fe[s];
            cap_bk   = bk[s];
        end
        if (bsy[s] && !busy_prev) busy_rise = cyc;
        if (!bsy[s] && busy_prev) busy_fall = cyc;
        vld_prev  = vld[s];
        busy_prev = bsy[s];
        rdy[s] = (cyc == rdy_pulse_at - 1) ? 1'b1 : rdy_level;
    endtask

    task automatic start_test(input int s);
        cyc = 0; ovr_cnt = 0; rise_cnt = 0; rise_cyc = 0; busy_rise = 0; busy_fall = 0;
        vld_prev  = vld[s];
        busy_prev = bsy[s];
    endtask

    task automatic idle(input int s, input int n);
        line[s] = 1'b1;
        repeat (n) tick(s);
    endtask

    // gl: step within the frame at which the line is inverted for one cycle (-1: none)
    task automatic send(input int s, input logic [15:0] fr, input int n, input int gl);
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < CD[s]; c++) begin
                line[s] = fr[b] ^ ((b * CD[s] + c) == gl);
                tick(s);
            end
        end
    endtask

    function automatic logic [15:0] build(input int s, input int data, input logic pbit,
                                          input logic st0, input logic st1, output int n);
        logic [15:0] f;
        logic [31:0] d;
        d = data;
        f = '1;
        f[0] = 1'b0;
        n = 1;
        for (int i = 0; i < DB[s]; i++) begin
            f[n] = d[i];
            n++;
        end
        if (PM[s] != 0) begin
            f[n] = pbit;
            n++;
        end
        f[n] = st0;
        n++;
        if (SB[s] == 2) begin
            f[n] = st1;
            n++;
        end
        return f;
    endfunction

    // Expected {break, frame, parity, data} for one frame from its bit-level content.
    function automatic logic [10:0] model(input int s, input int data, input logic pbit,
                                          input logic st0, input logic st1);
        int   d, ones;
        logic pe_e, fe_e, bk_e;
        d = data % (1 << DB[s]);
        ones = 0;
        for (int i = 0; i < DB[s]; i++) ones += (d >> i) & 1;
        if (PM[s] == 1)      pe_e = ((ones + int'(pbit)) % 2) != 0;
        else if (PM[s] == 2) pe_e = ((ones + int'(pbit)) % 2) == 0;
        else                 pe_e = 1'b0;
        fe_e = !st0 || (SB[s] == 2 && !st1);
        bk_e = fe_e && (d == 0) && (PM[s] == 0 || !pbit);
        return {bk_e, fe_e, pe_e, 8'(d)};
    endfunction

    task automatic run_frame(input int s, input int data, input logic pbit, input logic st0,
                             input logic st1, input int gl, input string tag);
        logic [15:0] fr;
        logic [10:0] e;
        int          n;
        fr = build(s, data, pbit, st0, st1, n);
        e  = model(s, data, pbit, st0, st1);
        start_test(s);
        send(s, fr, n, gl);
        idle(s, 2 * CD[s]);
        chk({tag, ".count"}, rise_cnt, 1);
        chk({tag, ".latency"}, rise_cyc, 3 + (n - 1) * CD[s] + CD[s] / 2 + 2);
        chk({tag, ".data"}, cap_data, e[7:0]);
        chk({tag, ".parity_err"}, cap_pe, e[8]);
        chk({tag, ".frame_err"}, cap_fe, e[9]);
        chk({tag, ".break_det"}, cap_bk, e[10]);
        chk({tag, ".overrun"}, ovr_cnt, 0);
    endtask

    function automatic logic even_par(input int d);
        logic [31:0] v;
        v = d;
        return ^v[7:0];
    endfunction

    initial begin
        logic [15:0] fr;
        int          n, d;
        logic        pb, s0, s1;

        rdy_level = 1'b1;
        rdy_pulse_at = 0;
        for (int i = 0; i < 3; i++) begin
            line[i] = 1'b1;
            rdy[i]  = 1'b1;
        end
        rst_n = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset%0d.data", i), dat[i], 0);
            chk($sformatf("reset%0d.valid", i), vld[i], 0);
            chk($sformatf("reset%0d.flags", i), {pe[i], fe[i], bk[i], ov[i], bsy[i]}, 0);
        end
        rst_n = 1'b1;
        idle(0, 5);

        run_frame(0, 'hA5, 1'b0, 1'b1, 1'b1, -1, "a5_even_ok");
        chk("a5_default_latency", rise_cyc, 456);
        run_frame(0, 'hA5, 1'b1, 1'b1, 1'b1, -1, "a5_even_bad");
        run_frame(1, 'hA5, 1'b1, 1'b1, 1'b1, -1, "a5_odd_ok");
        run_frame(0, 'h3C, 1'b0, 1'b0, 1'b1, -1, "3c_stop0");
        run_frame(0, 'h00, 1'b0, 1'b0, 1'b1, -1, "break");

        start_test(0);
        line[0] = 1'b0;
        repeat (10) tick(0);
        idle(0, 100);
        chk("false_start.busy_rise", busy_rise, 3);
        chk("false_start.busy_fall", busy_fall, 3 + CD[0] / 2 + 2);
        chk("false_start.no_valid", rise_cnt, 0);

        d = $urandom_range(0, 255);
        run_frame(0, d, even_par(d), 1'b1, 1'b1, 4 * CD[0] + CD[0] / 2 + 1, "glitch");

        rdy_level = 1'b0;
        rdy[0] = 1'b0;
        start_test(0);
        fr = build(0, 'h11, even_par('h11), 1'b1, 1'b1, n);
        send(0, fr, n, -1);
        fr = build(0, 'h22, even_par('h22), 1'b1, 1'b1, n);
        send(0, fr, n, -1);
        idle(0, 90);
        chk("ovr.loads", rise_cnt, 1);
        chk("ovr.held_data", dat[0], 'h11);
        chk("ovr.valid", vld[0], 1);
        chk("ovr.pulses", ovr_cnt, 1);
        rdy_level = 1'b1;
        rdy[0] = 1'b1;
        idle(0, 2);
        chk("ovr.drain_valid", vld[0], 0);
        chk("ovr.drain_data", dat[0], 'h11);

        rdy_level = 1'b0;
        rdy[0] = 1'b0;
        start_test(0);
        rdy_pulse_at = 2 * 11 * CD[0] - 11 * CD[0] + 456;
        fr = build(0, 'h11, even_par('h11), 1'b1, 1'b1, n);
        send(0, fr, n, -1);
        fr = build(0, 'h22, even_par('h22), 1'b1, 1'b1, n);
        send(0, fr, n, -1);
        idle(0, 90);
        rdy_pulse_at = 0;
        chk("reload.data", dat[0], 'h22);
        chk("reload.valid", vld[0], 1);
        chk("reload.no_overrun", ovr_cnt, 0);
        rdy_level = 1'b1;
        rdy[0] = 1'b1;
        idle(0, 2);

        run_frame(2, 'h55, 1'b0, 1'b1, 1'b1, -1, "7n2_55");

        start_test(2);
        line[2] = 1'b0;
        repeat (60) tick(2);
        chk("midreset.busy_before", bsy[2], 1);
        rst_n = 1'b0;
        line[2] = 1'b1;
        tick(2);
        tick(2);
        chk("midreset.data", dat[2], 0);
        chk("midreset.valid", vld[2], 0);
        chk("midreset.flags", {pe[2], fe[2], bk[2], ov[2], bsy[2]}, 0);
        rst_n = 1'b1;
        idle(2, 3);
        chk("midreset.no_overrun", ovr_cnt, 0);
        run_frame(2, 'h2A, 1'b0, 1'b1, 1'b1, -1, "7n2_after_reset");

        for (int i = 0; i < 6; i++) begin
            d  = $urandom_range(0, 255);
            pb = 1'($urandom_range(0, 1));
            s0 = ($urandom_range(0, 4) != 0);
            run_frame(i % 2, d, pb, s0, 1'b1, -1, $sformatf("rand%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            d  = $urandom_range(0, 127);
            s0 = ($urandom_range(0, 3) != 0);
            s1 = ($urandom_range(0, 3) != 0);
            run_frame(2, d, 1'b0, s0, s1, -1, $sformatf("rand7n2_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive core: the next generation of the fixed 8E1 receiver, with configurable divider, data width, parity mode and stop-bit count. Adds 3-sample majority voting, false-start rejection, separate parity/framing/break/overrun reporting, and a one-entry ready/valid holding register. Sits between the board RX pin and the byte-assembly front end of the AES encrypt/decrypt datapaths.

## Interface
- CLK_DIV, 43: sys_clk cycles per bit (5 MHz / 115200); legal range 8..4095
- DATA_BITS, 8: data bits per frame, 5..8, LSB first
- PARITY, 1: 0 none, 1 even, 2 odd
- STOP_BITS, 1: 1 or 2

- sys_clk  in  1  single clock
- rst_n  in  1  synchronous, active-low reset
- uart_rx  in  1  asynchronous serial line, idle high
- rx_data  out  8  received byte, zero-extended above DATA_BITS
- rx_valid  out  1  holding register full
- rx_ready  in  1  consumer accepts rx_data this cycle
- parity_err  out  1  qualifies rx_data; parity mismatch (0 when PARITY=0)
- frame_err  out  1  qualifies rx_data; any stop bit sampled 0
- break_det  out  1  qualifies rx_data; frame_err with all data and parity bits 0
- overrun  out  1  one-cycle pulse, completed frame discarded
- rx_busy  out  1  high whenever FSM is not IDLE

## Operation
- uart_rx passes through 2-flop synchroniser (reset to 1); falling edge = sync output 0 with previous 1.
- Bit timer clk_cnt 0..CLK_DIV-1, width $clog2(CLK_DIV); samples at CLK_DIV/2-1, CLK_DIV/2, CLK_DIV/2+1; bit value = majority of 3, resolved at CLK_DIV/2+1 ("sample point").
- FSM: IDLE -> START on falling edge, clk_cnt cleared. START: majority 1 at sample point -> IDLE (false start, no output); else -> DATA at clk_cnt wrap. DATA: DATA_BITS bits shifted LSB first -> PARITY (if PARITY!=0) else STOP. PARITY: one bit -> STOP. STOP: STOP_BITS bits; frame completes at sample point of last stop bit, FSM -> IDLE same edge, so the next start edge is detectable immediately.
- Even: parity_err = XOR(data, parity bit); odd: its inverse.
- Frame completion with errors still delivers data plus flags.
- Completion while rx_valid=0, or rx_valid=1 and rx_ready=1: load rx_data/flags, rx_valid=1.
- Completion while rx_valid=1 and rx_ready=0: held data/flags unchanged, new frame dropped, overrun pulses 1 cycle.
- rx_valid & rx_ready without completion: rx_valid=0; rx_data and flags retain value until next load.

## Timing
- Reset: all outputs 0, FSM IDLE, counters 0, synchroniser 1s; reset mid-frame aborts frame with no output and no overrun.
- Frame length F = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bits.
- rx_valid rises 3 + (F-1)*CLK_DIV + CLK_DIV/2 + 2 cycles after uart_rx pin falls (defaults: 456).
- rx_data/flags change only on the edge rx_valid is set/reloaded.
- Glitch shorter than 2 cycles at a sample window does not change the sampled bit.
- Back-to-back frames with zero idle time received without loss.

## Structure
- Package uart_pkg: parity constants PAR_NONE/PAR_EVEN/PAR_ODD, FSM state encoding, $clog2-based counter-width helper.
- Sub-module uart_rx_sampler: synchroniser, edge detect, 3-sample majority; FSM, shift register and holding register stay in uart_rx_core.

## Test plan
- Defaults, send 0xA5 with even parity bit 0, stop 1 -> rx_data=0xA5, rx_valid at cycle 456, no flags.
- Same 0xA5 with parity bit 1 -> rx_data=0xA5, parity_err=1; PARITY=2 with bit 1 -> no error.
- Stop bit 0 on 0x3C -> frame_err=1; all-zero frame incl. parity and stop -> frame_err=1, break_det=1, rx_data=0x00.
- 10-cycle low pulse on idle line -> no rx_valid, rx_busy returns low after CLK_DIV/2+2+3 cycles; single-cycle glitch at data mid-bit -> byte correct.
- rx_ready held 0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun pulses once; rx_ready=1 on the completion cycle of 0x22 -> 0x22 loaded, no overrun.
- DATA_BITS=7, PARITY=0, STOP_BITS=2, CLK_DIV=16, send 0x55 -> rx_data=0x55; reset asserted mid-byte -> outputs 0, next frame received correctly.
